// File: rtl/dispatch_tag_alloc.sv
// dispatch_tag_alloc: read side of the free-tag FIFO. Prefetches up to two free
//   tags into a small buffer and hands them to dispatch over a req/gnt handshake.
// Latency: a buffered tag is granted in the same cycle alloc_req is raised;
//   a tag popped at edge N is grantable from cycle N+1.
// Backpressure: pops stop while the buffer is full and not granting. A flush
//   blocks pop and grant for the flush cycle and one following settle cycle.
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   flush            pipeline flush; drops buffered tags
//   tf_tagout/tf_ef  tag FIFO head and empty flag
//   tf_ren           pop strobe to the tag FIFO (combinational)
//   alloc_req/gnt    dispatch request / grant (grant combinational)
//   alloc_tag        granted tag (0 while the buffer is empty)
//   tag_avail        registered: buffer holds at least one tag
//   stall_cnt        saturating count of requested-but-not-granted cycles
module dispatch_tag_alloc #(
  parameter int TAG_WIDTH = 6,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [TAG_WIDTH-1:0] tf_tagout,
  input  logic                 tf_ef,
  output logic                 tf_ren,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 tag_avail,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_PART   = 2'd1,
    S_FULL   = 2'd2,
    S_FLWAIT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_buf_q [2];
  logic [TAG_WIDTH-1:0]   tag_buf_d [2];
  logic                   head_q, head_d;
  logic [CNT_WIDTH-1:0]   stall_q, stall_d;
  logic                   tag_avail_q, tag_avail_d;

  logic [1:0]             count;
  logic                   flw;
  logic                   tail;
  logic                   gnt;
  logic                   ren;

  always_comb begin
    // The state encodes the occupancy directly, so count never disagrees with it.
    count = 2'd0;
    case (state_q)
      S_PART:  count = 2'd1;
      S_FULL:  count = 2'd2;
      default: count = 2'd0;
    endcase
    flw = (state_q == S_FLWAIT);

    gnt = alloc_req & (count != 2'd0) & ~flush & ~flw & ~reset;
    // A full buffer may still pop when it grants: the freed slot takes the new tag.
    ren = ~tf_ef & ~flush & ~flw & ((count != 2'd2) | gnt) & ~reset;

    // Slot just past the last held tag (mod 2). With two tags held this is the
    // head slot, which is exactly the one vacated by a simultaneous grant.
    tail = head_q ^ count[0];

    tag_buf_d = tag_buf_q;
    if (ren) begin
      tag_buf_d[tail] = tf_tagout;
    end

    head_d = gnt ? ~head_q : head_q;

    state_d = state_q;
    case (state_q)
      S_EMPTY:  if (ren) state_d = S_PART;
      S_PART: begin
        if (ren && !gnt)      state_d = S_FULL;
        else if (gnt && !ren) state_d = S_EMPTY;
      end
      S_FULL:   if (gnt && !ren) state_d = S_PART;
      default:  state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d = S_FLWAIT;
      head_d  = 1'b0;
    end

    stall_d = stall_q;
    if (alloc_req && !gnt && !flw && !flush && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end

    tag_avail_d = (state_d == S_PART) || (state_d == S_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      tag_buf_q[0] <= '0;
      tag_buf_q[1] <= '0;
      head_q       <= 1'b0;
      stall_q      <= '0;
      tag_avail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_buf_q[0] <= tag_buf_d[0];
      tag_buf_q[1] <= tag_buf_d[1];
      head_q       <= head_d;
      stall_q      <= stall_d;
      tag_avail_q  <= tag_avail_d;
    end
  end

  assign tf_ren    = ren;
  assign alloc_gnt = gnt;
  assign alloc_tag = (count != 2'd0) ? tag_buf_q[head_q] : '0;
  assign tag_avail = tag_avail_q;
  assign stall_cnt = stall_q;

endmodule
